// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode constants, ALUOp codes and datapath mux select codes.
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN (adds ADDIEX/ADDIWB states).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        ,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Load and store share the address-calculation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output decode for the multicycle controller.
// Everything is a function of the state, except the instruction-register
// and PC write strobes in FETCH which follow mem_ready.
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output logic [1:0] o_alu_op,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_source
);

    // Per-state strobe/select table; anything not named for a state is 0.
    always_comb begin
        o_alu_op        = ALUOP_ADD;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_REG;
        o_pc_source     = PCSRC_ALU;
        case (i_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_BOFS;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            S_BEQEX: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
            end
            S_JEX: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                o_reg_write = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: state register, opcode latch and
// illegal-opcode pulse; output decode lives in mc_output_decode.
// Optional feature macro: MULTICYCLE_CONTROL_ADDI_EN (ADDI execute path;
// without it opcode 001000 is treated as illegal).
//
// state   | meaning
// --------+---------------------------------------------------
// FETCH   | read instruction, PC+4; wait for mem_ready
// DECODE  | register read, branch target; sample/latch opcode
// MEMADR  | effective address for LW/SW
// MEMRD   | data read; wait for mem_ready
// MEMWB   | load result to rt
// MEMWR   | data write; wait for mem_ready
// RTYPEEX | ALU op from funct
// RTYPEWB | ALU result to rd
// BEQEX   | compare, conditional PC update
// JEX     | jump target to PC
// ADDIEX  | rs + imm (ADDI build only)
// ADDIWB  | result to rt (ADDI build only)
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic       r_illegal;
    logic       w_illegal;

    // Next-state selection; unknown encodings recover to FETCH.
    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(opcode)) begin
                    w_next = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    w_next = S_RTYPEEX;
                end else if (opcode == OP_BEQ) begin
                    w_next = S_BEQEX;
                end else if (opcode == OP_J) begin
                    w_next = S_JEX;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
                end else if (opcode == OP_ADDI) begin
                    w_next = S_ADDIEX;
`endif
                end else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            // Load/store choice uses the latched opcode, not the live input.
            S_MEMADR:  w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_RTYPEWB: w_next = S_FETCH;
            S_BEQEX:   w_next = S_FETCH;
            S_JEX:     w_next = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
`endif
            default:   w_next = S_FETCH;
        endcase
    end

    // State register, opcode latch and one-cycle illegal pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_opcode  <= 6'b000000;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    mc_output_decode u_decode (
        .i_state         (r_state),
        .i_mem_ready     (mem_ready),
        .o_alu_op        (alu_op),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_iord          (iord),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_pc_source     (pc_source)
    );

    assign illegal_op = r_illegal;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected state and
// outputs are queued as stimulus is planned and compared as cycles elapse.
module tb_multicycle_control;

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] JEX     = 4'd9;
    localparam logic [3:0] ADDIEX  = 4'd10;
    localparam logic [3:0] ADDIWB  = 4'd11;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  st;
        logic [5:0]  opc;
        logic        mr;
        logic [16:0] outs;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
    );

    wire [16:0] act_outs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                            ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                            alu_src_b, pc_source, alu_op, illegal_op};

    // Expected outputs per state, written from the controller's output table.
    function automatic logic [16:0] exp_out(input logic [3:0] st, input logic mr,
                                            input logic ill);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rd = 0, rw = 0, sa = 0;
        logic [1:0] sb_ = 2'b00, ps = 2'b00, ao = 2'b00;
        case (st)
            FETCH:   begin mrd = 1; sb_ = 2'b01; irw = mr; pw = mr; end
            DECODE:  sb_ = 2'b11;
            MEMADR:  begin sa = 1; sb_ = 2'b10; end
            MEMRD:   begin io = 1; mrd = 1; end
            MEMWB:   begin rw = 1; m2r = 1; end
            MEMWR:   begin io = 1; mwr = 1; end
            RTYPEEX: begin sa = 1; ao = 2'b10; end
            RTYPEWB: begin rd = 1; rw = 1; end
            BEQEX:   begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            JEX:     begin pw = 1; ps = 2'b10; end
            ADDIEX:  begin sa = 1; sb_ = 2'b10; end
            ADDIWB:  rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb_, ps, ao, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] opc,
                        input logic mr, input logic ill);
        ent_t e;
        e.st = st; e.opc = opc; e.mr = mr; e.outs = exp_out(st, mr, ill);
        sb.push_back(e);
    endtask

    // Plan one instruction: fetch waits, decode, execute path with memory waits.
    task automatic push_instr(input logic [5:0] op, input int nwait);
        logic [5:0] junk;
        junk = (op == LW) ? SW : LW;
        for (int i = 0; i < nwait; i++) push(FETCH, junk, 1'b0, 1'b0);
        push(FETCH, junk, 1'b1, 1'b0);
        push(DECODE, op, 1'b1, 1'b0);
        if (op == LW) begin
            push(MEMADR, junk, 1'b1, 1'b0);
            for (int i = 0; i < nwait; i++) push(MEMRD, junk, 1'b0, 1'b0);
            push(MEMRD, junk, 1'b1, 1'b0);
            push(MEMWB, junk, 1'b0, 1'b0);
        end else if (op == SW) begin
            push(MEMADR, junk, 1'b1, 1'b0);
            for (int i = 0; i < nwait; i++) push(MEMWR, junk, 1'b0, 1'b0);
            push(MEMWR, junk, 1'b1, 1'b0);
        end else if (op == RT) begin
            push(RTYPEEX, junk, 1'b0, 1'b0);
            push(RTYPEWB, junk, 1'b0, 1'b0);
        end else if (op == BEQ) begin
            push(BEQEX, junk, 1'b0, 1'b0);
        end else if (op == JMP) begin
            push(JEX, junk, 1'b0, 1'b0);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        end else if (op == ADDI) begin
            push(ADDIEX, junk, 1'b0, 1'b0);
            push(ADDIWB, junk, 1'b0, 1'b0);
`endif
        end else begin
            push(FETCH, junk, 1'b0, 1'b1);
        end
    endtask

    // Drain the scoreboard: one entry per clock, compared mid-cycle.
    task automatic run_cycles(input string name);
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc;
            mem_ready = e.mr;
            @(negedge clk);
            n_checks++;
            if (state_o !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d at %0t", name, state_o, e.st, $time);
            end
            n_checks++;
            if (act_outs !== e.outs) begin
                n_fail++;
                $display("FAIL %s outputs (state %0d): got %b expected %b at %0t",
                         name, e.st, act_outs, e.outs, $time);
            end
            @(posedge clk); #1;
        end
    endtask

    // mem_read and mem_write must never be asserted together.
    always @(negedge clk) begin
        n_checks++;
        if (mem_read && mem_write) begin
            n_fail++;
            $display("FAIL mem_rw_exclusive: mem_read=%b mem_write=%b at %0t",
                     mem_read, mem_write, $time);
        end
    end

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = BAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (state_o !== FETCH) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_o, FETCH);
        end
        n_checks++;
        if (act_outs !== exp_out(FETCH, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b",
                               act_outs, exp_out(FETCH, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push(FETCH, BAD, 1'b0, 1'b0);
        push_instr(RT, 0);
        run_cycles("reset_release");
    endtask

    task automatic test_lw();
        push_instr(LW, 0);
        run_cycles("lw");
        push_instr(LW, 2);
        run_cycles("lw_wait");
    endtask

    task automatic test_rtype();
        push_instr(RT, 0);
        run_cycles("rtype");
    endtask

    task automatic test_sw_wait();
        push_instr(SW, 3);
        run_cycles("sw_wait");
    endtask

    task automatic test_branch_jump();
        push_instr(BEQ, 0);
        push_instr(JMP, 1);
        run_cycles("beq_j");
    endtask

    task automatic test_illegal();
        push_instr(BAD, 0);
        push(FETCH, LW, 1'b0, 1'b0);
        run_cycles("illegal");
        push_instr(ADDI, 0);
        push(FETCH, LW, 1'b0, 1'b0);
        run_cycles("addi");
    endtask

    task automatic test_reset_in_memrd();
        push(FETCH, SW, 1'b1, 1'b0);
        push(DECODE, LW, 1'b1, 1'b0);
        push(MEMADR, SW, 1'b1, 1'b0);
        push(MEMRD, SW, 1'b0, 1'b0);
        run_cycles("memrd_pre_reset");
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (state_o !== FETCH) begin
            n_fail++; $display("FAIL reset_memrd_state: got %0d expected %0d", state_o, FETCH);
        end
        n_checks++;
        if (iord !== 1'b0 || reg_write !== 1'b0 || illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL reset_memrd_strobes: iord=%b reg_write=%b illegal=%b expected 0",
                               iord, reg_write, illegal_op);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push_instr(SW, 0);
        run_cycles("after_memrd_reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
        ops[4] = JMP; ops[5] = ADDI; ops[6] = BAD;
        for (int k = 0; k < 40; k++)
            push_instr(ops[$urandom_range(0, 6)], int'($urandom_range(0, 2)));
        push(FETCH, LW, 1'b0, 1'b0);
        run_cycles("back_to_back");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_branch_jump();
        test_illegal();
        test_reset_in_memrd();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
